// File: rtl/inert_sched.sv
// Inertial sensor SPI scheduler: power-up delay, register setup writes, then INT-driven 10-read bursts.
// Optional per-transaction watchdog reissue is compiled in with `define INERT_SCHED_TMO_EN.
module inert_sched #(
  parameter int PWR_DLY = 65535,
  parameter int TMO_CYC = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        snd,
  output logic [15:0] cmd,
  output logic        setup_done,
  output logic        burst_vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic [15:0] ax,
  output logic [15:0] ay
);

  localparam int PW = (PWR_DLY > 2) ? $clog2(PWR_DLY) : 1;

  typedef enum logic [2:0] {
    PWR   = 3'd0,
    SETUP = 3'd1,
    IDLE  = 3'd2,
    READ  = 3'd3,
    VLD   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic          int_meta_r, int_sync_r;
  logic [PW-1:0] pwr_cnt_r;
  logic [1:0]    wr_idx_r;
  logic [3:0]    rd_idx_r;
  logic          pend_r;
  logic [7:0]    hold_r;
  logic          snd_r, setup_done_r, burst_vld_r;
  logic [15:0]   cmd_r, ptch_r, roll_r, yaw_r, ax_r, ay_r;
  logic          pwr_end_s, acc_s, issue_s, tmo_s, snd_s, burst_vld_s;
  logic [15:0]   cmd_s;
  logic          unused_hi_s;

  function automatic logic [15:0] wr_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    wr_cmd = 16'h0D02;
      2'd1:    wr_cmd = 16'h1053;
      2'd2:    wr_cmd = 16'h1150;
      default: wr_cmd = 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [3:0] idx);
    rd_cmd = {1'b1, 7'h22 + {3'b000, idx}, 8'h00};
  endfunction

  // done only completes an outstanding transaction, and never in the cycle snd is launched
  assign pwr_end_s   = (pwr_cnt_r == PW'(PWR_DLY - 1));
  assign acc_s       = pend_r & done & ~snd_r;
  assign unused_hi_s = ^rd_data[15:8];

`ifdef INERT_SCHED_TMO_EN
  localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_s = pend_r & ~acc_s & (tmo_cnt_r == TW'(TMO_CYC - 1));

  // Watchdog: counts cycles of an outstanding transaction, restarting on each (re)issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (!pend_r || tmo_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end
`else
  localparam int unused_tmo = TMO_CYC;
  assign tmo_s = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous data-ready line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_meta_r <= 1'b0;
      int_sync_r <= 1'b0;
    end else begin
      int_meta_r <= INT;
      int_sync_r <= int_meta_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= PWR;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      PWR:     if (pwr_end_s) state_s = SETUP; else state_s = PWR;
      SETUP:   if (acc_s && wr_idx_r == 2'd3) state_s = IDLE; else state_s = SETUP;
      IDLE:    if (int_sync_r) state_s = READ; else state_s = IDLE;
      READ:    if (acc_s && rd_idx_r == 4'd9) state_s = VLD; else state_s = READ;
      VLD:     state_s = IDLE;
      default: state_s = PWR;
    endcase
  end

  // Output logic: launches the next command; IDLE launches read 0 on the same edge it leaves
  always_comb begin
    issue_s     = 1'b0;
    cmd_s       = cmd_r;
    burst_vld_s = 1'b0;
    case (state_r)
      SETUP: begin
        if (!pend_r) begin
          issue_s = 1'b1;
          cmd_s   = wr_cmd(wr_idx_r);
        end else begin
          issue_s = 1'b0;
        end
      end
      IDLE: begin
        if (int_sync_r) begin
          issue_s = 1'b1;
          cmd_s   = rd_cmd(4'd0);
        end else begin
          issue_s = 1'b0;
        end
      end
      READ: begin
        if (!pend_r) begin
          issue_s = 1'b1;
          cmd_s   = rd_cmd(rd_idx_r);
        end else begin
          issue_s = 1'b0;
        end
        burst_vld_s = acc_s & (rd_idx_r == 4'd9);
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
    snd_s = issue_s | tmo_s;
  end

  // Transaction bookkeeping, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_cnt_r    <= '0;
      wr_idx_r     <= 2'd0;
      rd_idx_r     <= 4'd0;
      pend_r       <= 1'b0;
      hold_r       <= 8'h00;
      snd_r        <= 1'b0;
      cmd_r        <= 16'h0000;
      setup_done_r <= 1'b0;
      burst_vld_r  <= 1'b0;
      ptch_r       <= 16'h0000;
      roll_r       <= 16'h0000;
      yaw_r        <= 16'h0000;
      ax_r         <= 16'h0000;
      ay_r         <= 16'h0000;
    end else begin
      snd_r       <= snd_s;
      cmd_r       <= cmd_s;
      burst_vld_r <= burst_vld_s;
      if (state_r == PWR && !pwr_end_s) pwr_cnt_r <= pwr_cnt_r + PW'(1);
      if (issue_s)    pend_r <= 1'b1;
      else if (acc_s) pend_r <= 1'b0;
      if (state_r == SETUP && acc_s) begin
        if (wr_idx_r == 2'd3) setup_done_r <= 1'b1;
        else                  wr_idx_r     <= wr_idx_r + 2'd1;
      end
      if (state_r == IDLE && int_sync_r) begin
        rd_idx_r <= 4'd0;
      end else if (state_r == READ && acc_s) begin
        if (rd_idx_r != 4'd9) rd_idx_r <= rd_idx_r + 4'd1;
        // even index is a low byte; the word is written whole on its high byte
        if (!rd_idx_r[0]) begin
          hold_r <= rd_data[7:0];
        end else begin
          case (rd_idx_r[3:1])
            3'd0:    ptch_r <= {rd_data[7:0], hold_r};
            3'd1:    roll_r <= {rd_data[7:0], hold_r};
            3'd2:    yaw_r  <= {rd_data[7:0], hold_r};
            3'd3:    ax_r   <= {rd_data[7:0], hold_r};
            3'd4:    ay_r   <= {rd_data[7:0], hold_r};
            default: ay_r   <= ay_r;
          endcase
        end
      end
    end
  end

  assign snd        = snd_r;
  assign cmd        = cmd_r;
  assign setup_done = setup_done_r;
  assign burst_vld  = burst_vld_r;
  assign ptch_rt    = ptch_r;
  assign roll_rt    = roll_r;
  assign yaw_rt     = yaw_r;
  assign ax         = ax_r;
  assign ay         = ay_r;

endmodule

// File: tb/tb_inert_sched.sv
// Directed self-checking bench for inert_sched (PWR_DLY=16, TMO_CYC=32).
module tb_inert_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        snd, setup_done, burst_vld;
  logic [15:0] cmd, ptch_rt, roll_rt, yaw_rt, ax, ay;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int bv_cnt = 0;
  int rel;

  logic [7:0] b1 [10] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h01, 8'h80, 8'hFF, 8'h7F};
  logic [7:0] b2 [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

  inert_sched #(.PWR_DLY(16), .TMO_CYC(32)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .snd(snd), .cmd(cmd), .setup_done(setup_done), .burst_vld(burst_vld),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt), .ax(ax), .ay(ay)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;
  always @(negedge clk) if (burst_vld) bv_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_snd(input int lim);
    int i;
    i = 0;
    while (snd !== 1'b1 && i < lim) begin
      @(negedge clk);
      i++;
    end
    check_eq("snd_seen", snd, 1'b1);
  endtask

  task automatic xact(input string tag, input logic [15:0] exp_cmd, input logic [7:0] b);
    wait_snd(300);
    check_eq(tag, cmd, exp_cmd);
    @(negedge clk);
    check_eq("snd_one_cycle", snd, 1'b0);
    repeat (7) @(negedge clk);
    check_eq("cmd_hold", cmd, exp_cmd);
    done = 1'b1;
    rd_data = {8'hEE, b};
    @(negedge clk);
    done = 1'b0;
    rd_data = 16'h0000;
  endtask

  task automatic check_zero_outs(input string tag);
    check_eq(tag, {snd, setup_done, burst_vld, |cmd,
                   |{ptch_rt, roll_rt, yaw_rt, ax, ay}}, 32'd0);
  endtask

  initial begin
    int n, delta;
    repeat (3) @(negedge clk);
    check_zero_outs("reset_outs");

    // Power-up delay and setup writes
    rst = 1'b0;
    rel = edge_n;
    wait_snd(40);
    check_eq("first_snd_clk", edge_n - rel, 32'd17);
    xact("w0", 16'h0D02, 8'h00);
    xact("w1", 16'h1053, 8'h00);
    xact("w2", 16'h1150, 8'h00);
    check_eq("setup_not_done", setup_done, 1'b0);
    xact("w3", 16'h1460, 8'h00);
    check_eq("setup_done_rise", setup_done, 1'b1);

    // Spurious done in IDLE
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (snd) n++;
    end
    check_eq("spur_no_snd", n, 32'd0);
    check_eq("spur_outs", {ptch_rt, ay}, 32'd0);
    check_eq("spur_setup", setup_done, 1'b1);

    // Burst 1 with INT held high
    INT = 1'b1;
    for (int i = 0; i < 10; i++) xact("rd1", 16'hA200 + 16'(i * 256), b1[i]);
    check_eq("b1_vld", burst_vld, 1'b1);
    check_eq("b1_ptch", ptch_rt, 16'h1234);
    check_eq("b1_roll", roll_rt, 16'h5678);
    check_eq("b1_yaw", yaw_rt, 16'h9ABC);
    check_eq("b1_ax", ax, 16'h8001);
    check_eq("b1_ay", ay, 16'h7FFF);
    @(negedge clk);
    check_eq("b1_vld_once", burst_vld, 1'b0);
    @(negedge clk);
    check_eq("b2_immediate", snd, 1'b1);

    // Burst 2: INT activity during READ only, low at IDLE entry
    for (int i = 0; i < 10; i++) begin
      if (i == 1) INT = 1'b0;
      if (i == 4) INT = 1'b1;
      if (i == 6) INT = 1'b0;
      xact("rd2", 16'hA200 + 16'(i * 256), b2[i]);
      if (i == 0) check_eq("no_partial", ptch_rt, 16'h1234);
    end
    check_eq("b2_vld", burst_vld, 1'b1);
    check_eq("b2_ptch", ptch_rt, 16'h2211);
    check_eq("b2_ay", ay, 16'hAA99);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snd) n++;
    end
    check_eq("no_third_burst", n, 32'd0);
    check_eq("bv_pulses", bv_cnt, 32'd2);

    // Reset after the 5th read is launched
    INT = 1'b1;
    for (int i = 0; i < 4; i++) xact("rd3", 16'hA200 + 16'(i * 256), b1[i]);
    INT = 1'b0;
    wait_snd(20);
    check_eq("rd5_cmd", cmd, 16'hA600);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outs("midrst_outs");
    rst = 1'b0;
    rel = edge_n;
    wait_snd(40);
    check_eq("rerun_snd_clk", edge_n - rel, 32'd17);
    xact("rw0", 16'h0D02, 8'h00);

    // Withheld done on the 2nd setup write
    wait_snd(300);
    check_eq("tmo_cmd", cmd, 16'h1053);
    rel = edge_n;
    n = 0;
    delta = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (snd) begin
        if (n == 0) delta = edge_n - rel;
        n++;
        check_eq("tmo_recmd", cmd, 16'h1053);
      end
    end
`ifdef INERT_SCHED_TMO_EN
    check_eq("tmo_reissues", n, 32'd1);
    check_eq("tmo_delta", delta, 32'd32);
`else
    check_eq("no_reissue", n, 32'd0);
`endif
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    xact("rw2", 16'h1150, 8'h00);
    xact("rw3", 16'h1460, 8'h00);
    check_eq("resetup_done", setup_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inert_sched.md
INERT_SCHED -- requirements
Module: inert_sched

Interface
REQ-001 Parameter: PWR_DLY, default 65535, clocks waited after reset before the first setup write.
REQ-002 Parameter: TMO_CYC, default 4095, clocks allowed per SPI transaction when the watchdog is compiled in.
REQ-003 Port: clk, in, 1, single system clock; all state on posedge.
REQ-004 Port: rst, in, 1, reset; asynchronous, active-high.
REQ-005 Port: INT, in, 1, sensor data-ready; asynchronous to clk.
REQ-006 Port: done, in, 1, one-cycle pulse from the SPI master marking transaction complete.
REQ-007 Port: rd_data, in, 16, SPI response; bits [7:0] carry the read byte.
REQ-008 Port: snd, out, 1, one-cycle pulse starting an SPI transaction.
REQ-009 Port: cmd, out, 16, SPI command: [15] 1=read/0=write, [14:8] address, [7:0] write data.
REQ-010 Port: setup_done, out, 1, high once all setup writes have completed.
REQ-011 Port: burst_vld, out, 1, one-cycle pulse when a full sample set is updated.
REQ-012 Ports: ptch_rt, roll_rt, yaw_rt, ax, ay, out, 16 each, signed sensor words.

Function
REQ-013 INT double-flopped before use; only the synchronized level is consumed.
REQ-014 FSM states: PWR, SETUP, IDLE, READ, VLD.
REQ-015 PWR: count PWR_DLY clocks, then enter SETUP.
REQ-016 SETUP: issue writes in order 0x0D02, 0x1053, 0x1150, 0x1460; one transaction outstanding at a time.
REQ-017 Transaction: snd high exactly one cycle with cmd valid that cycle; cmd held stable until done; next snd no earlier than the cycle after done.
REQ-018 After the 4th write's done, setup_done goes high the next cycle and stays high until reset; FSM enters IDLE.
REQ-019 IDLE: synchronized INT high -> enter READ and issue the first read within 1 clock.
REQ-020 READ: 10 reads in order, addresses 0x22 through 0x2B (cmd 0xA200..0xAB00), low byte then high byte for ptch_rt, roll_rt, yaw_rt, ax, ay.
REQ-021 Low byte latched into a holding register at done; output word updated to {high, low} at the done of its high byte, never partially.
REQ-022 After the 10th done -> VLD: burst_vld pulses exactly one cycle, then IDLE.
REQ-023 INT activity during SETUP or READ is ignored; INT still high on IDLE entry starts a new burst.
REQ-024 done while no transaction is outstanding is ignored; done coincident with snd is not accepted for that transaction.
REQ-025 Read/write index counters never wrap; the FSM exits at final count.

Reset
REQ-026 rst high: FSM -> PWR, all counters 0, snd 0, cmd 0x0000, setup_done 0, burst_vld 0, all data outputs 0x0000, INT synchronizer 0.
REQ-027 rst mid-transaction abandons it; after release the full PWR + SETUP sequence reruns.

Configuration
REQ-028 Macro INERT_SCHED_TMO_EN defined: cycle counter runs while a transaction is outstanding; at TMO_CYC clocks without done, the same cmd is reissued with a new snd pulse and the counter restarts.
REQ-029 Macro undefined: no watchdog logic; the FSM waits indefinitely for done.

Verification
REQ-030 Reset release, PWR_DLY=16, done returned 8 clocks after each snd -> first snd at clock 17 with cmd 0x0D02; cmds 0x0D02, 0x1053, 0x1150, 0x1460 in order; setup_done rises 1 clock after the 4th done.
REQ-031 After setup, INT held high; rd_data bytes 0x34, 0x12, 0x78, 0x56, 0xBC, 0x9A, 0x01, 0x80, 0xFF, 0x7F -> ptch_rt=0x1234, roll_rt=0x5678, yaw_rt=0x9ABC, ax=0x8001, ay=0x7FFF; exactly one burst_vld pulse.
REQ-032 INT toggled during READ and low on IDLE entry -> no second burst; INT high on IDLE entry -> second burst begins immediately.
REQ-033 rst asserted after 5th read's snd -> all outputs 0x0000, setup_done 0, setup sequence restarts from 0x0D02.
REQ-034 INERT_SCHED_TMO_EN defined, TMO_CYC=32, done withheld for the 2nd setup write -> snd reissued with 0x1053 32 clocks after the original snd; without the macro, no reissue.
REQ-035 Spurious done pulse in IDLE -> no state change, no snd, outputs unchanged.
